// File: rtl/counter_x_pkg.sv
// Shared definitions for the counter_x three-channel timer block.
// Modes, register-select codes and control-word field positions.
package counter_x_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_RATE    = 2'b01,
        MODE_SQUARE  = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_e;

    localparam logic [1:0] SEL_CH0  = 2'b00;
    localparam logic [1:0] SEL_CH1  = 2'b01;
    localparam logic [1:0] SEL_CH2  = 2'b10;
    localparam logic [1:0] SEL_CTRL = 2'b11;

    // Channel code 3 in a control word addresses no channel.
    localparam logic [1:0] CTRL_CH_NONE = 2'b11;

    localparam int CTRL_CH_LSB   = 0;
    localparam int CTRL_MODE_LSB = 2;
    localparam int CTRL_EN_BIT   = 4;
    localparam int CTRL_DIV_LSB  = 8;

    localparam int NUM_CH = 3;

endpackage

// File: rtl/counter_x_ch.sv
// counter_ch: one timer channel holding count, reload, mode, enable and event out.
module counter_ch
    import counter_x_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tick,
    input  logic        i_cnt_we,
    input  logic        i_ctrl_we,
    input  logic [1:0]  i_mode,
    input  logic        i_en,
    input  logic [31:0] i_val,
    output logic [31:0] o_count,
    output logic        o_en,
    output logic        o_out
);

    logic [31:0] r_count;
    logic [31:0] r_reload;
    mode_e       r_mode;
    logic        r_en;
    logic        r_out;

    logic [31:0] w_count_nxt;
    logic        w_out_nxt;
    logic        w_run;

    // Next count/out: a count write beats any terminal or reload event on the same edge.
    always_comb begin
        w_count_nxt = r_count;
        w_out_nxt   = r_out;
        w_run       = i_tick && r_en && (r_mode != MODE_HOLD) && (r_count != 32'd0);
        if (i_cnt_we) begin
            w_count_nxt = i_val;
            w_out_nxt   = 1'b0;
        end else begin
            if (r_mode == MODE_RATE) begin
                w_out_nxt = 1'b0;
            end else begin
                w_out_nxt = r_out;
            end
            if (w_run && (r_count == 32'd1)) begin
                case (r_mode)
                    MODE_ONESHOT: begin
                        w_count_nxt = 32'd0;
                        w_out_nxt   = 1'b1;
                    end
                    MODE_RATE: begin
                        w_count_nxt = r_reload;
                        w_out_nxt   = 1'b1;
                    end
                    MODE_SQUARE: begin
                        w_count_nxt = r_reload;
                        w_out_nxt   = ~r_out;
                    end
                    default: begin
                        w_count_nxt = r_count;
                        w_out_nxt   = r_out;
                    end
                endcase
            end else if (w_run) begin
                w_count_nxt = r_count - 32'd1;
            end else begin
                w_count_nxt = r_count;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= 32'd0;
            r_reload <= 32'd0;
            r_mode   <= MODE_ONESHOT;
            r_en     <= 1'b0;
            r_out    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_out   <= w_out_nxt;
            if (i_cnt_we) begin
                r_reload <= i_val;
            end else begin
                r_reload <= r_reload;
            end
            if (i_ctrl_we) begin
                r_mode <= mode_e'(i_mode);
                r_en   <= i_en;
            end else begin
                r_mode <= r_mode;
                r_en   <= r_en;
            end
        end
    end

    assign o_count = r_count;
    assign o_en    = r_en;
    assign o_out   = r_out;

endmodule

// File: rtl/counter_x.sv
// counter_x: three-channel down-counter peripheral with shared tick and read mux.
// Optional shared tick prescaler enabled by defining COUNTER_PRESCALE_EN.
module counter_x
    import counter_x_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        counter_we,
    input  logic [1:0]  counter_set,
    input  logic [31:0] counter_val,
    output logic [31:0] counter_out,
    output logic        counter0_out,
    output logic        counter1_out,
    output logic        counter2_out
);

    logic        w_tick;
    logic        w_ctrl_valid;
    logic [1:0]  w_ctrl_ch;
    logic [31:0] w_count [NUM_CH];
    logic        w_en    [NUM_CH];
    logic        w_out   [NUM_CH];

    assign w_ctrl_ch    = counter_val[CTRL_CH_LSB +: 2];
    assign w_ctrl_valid = counter_we && (counter_set == SEL_CTRL) && (w_ctrl_ch != CTRL_CH_NONE);

`ifdef COUNTER_PRESCALE_EN
    logic [7:0] r_div;
    logic [7:0] r_phase;

    // Shared prescaler: one tick every r_div+1 cycles, phase restarts on each divisor write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= 8'd0;
            r_phase <= 8'd0;
        end else if (w_ctrl_valid) begin
            r_div   <= counter_val[CTRL_DIV_LSB +: 8];
            r_phase <= 8'd0;
        end else if (w_tick) begin
            r_phase <= 8'd0;
        end else begin
            r_phase <= r_phase + 8'd1;
        end
    end

    assign w_tick = (r_phase == r_div);
`else
    assign w_tick = 1'b1;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        counter_ch u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_tick    (w_tick),
            .i_cnt_we  (counter_we && (counter_set == 2'(g))),
            .i_ctrl_we (w_ctrl_valid && (w_ctrl_ch == 2'(g))),
            .i_mode    (counter_val[CTRL_MODE_LSB +: 2]),
            .i_en      (counter_val[CTRL_EN_BIT]),
            .i_val     (counter_val),
            .o_count   (w_count[g]),
            .o_en      (w_en[g]),
            .o_out     (w_out[g])
        );
    end

    // Read-back mux for the selected register.
    always_comb begin
        case (counter_set)
            SEL_CH0:  counter_out = w_count[0];
            SEL_CH1:  counter_out = w_count[1];
            SEL_CH2:  counter_out = w_count[2];
            SEL_CTRL: counter_out = {24'h000000, w_en[2], w_en[1], w_en[0], 2'b00,
                                     w_out[2], w_out[1], w_out[0]};
            default:  counter_out = 32'h00000000;
        endcase
    end

    assign counter0_out = w_out[0];
    assign counter1_out = w_out[1];
    assign counter2_out = w_out[2];

endmodule
